// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: opcodes, FSM states,
// instruction classes and the pc_src / wb_sel / err output codes.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_e;

  // LUI, AUIPC, OP and OP-IMM share the plain ALU writeback path
  typedef enum logic [2:0] {
    IC_ALU    = 3'd0,
    IC_JAL    = 3'd1,
    IC_JALR   = 3'd2,
    IC_BRANCH = 3'd3,
    IC_LOAD   = 3'd4,
    IC_STORE  = 3'd5,
    IC_FENCE  = 3'd6,
    IC_SYSTEM = 3'd7
  } iclass_e;

  localparam logic [1:0] PC_SRC_PC4 = 2'd0;
  localparam logic [1:0] PC_SRC_IMM = 2'd1;
  localparam logic [1:0] PC_SRC_ALU = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/seq_opcode_decode.sv
// Combinational opcode classifier: maps instruction[6:0] to an instruction
// class and flags anything outside the supported RV32I base opcodes.
module seq_opcode_decode
  import rv32i_pkg::*;
(
  input  logic [6:0] i_opcode,
  output iclass_e    o_iclass,
  output logic       o_legal
);

  // classify opcode; unknown opcodes report illegal with a don't-care class
  always_comb begin
    o_iclass = IC_ALU;
    o_legal  = 1'b1;
    case (i_opcode)
      OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP: o_iclass = IC_ALU;
      OPC_JAL:    o_iclass = IC_JAL;
      OPC_JALR:   o_iclass = IC_JALR;
      OPC_BRANCH: o_iclass = IC_BRANCH;
      OPC_LOAD:   o_iclass = IC_LOAD;
      OPC_STORE:  o_iclass = IC_STORE;
      OPC_FENCE:  o_iclass = IC_FENCE;
      OPC_SYSTEM: o_iclass = IC_SYSTEM;
      default:    o_legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_sequencer.sv
// Multi-cycle timing FSM for the RV32I datapath (FETCH/DECODE/EXECUTE/MEM/
// WRITEBACK) with a single req/ready memory port and a memory wait timeout.
// Optional performance counters are built only when SEQ_PERF_CNT_EN is defined.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | out of reset, waiting for start
// FETCH     | instruction read at PC; IR loaded on mem_ready
// DECODE    | classify opcode; SYSTEM retires, illegal halts
// EXECUTE   | branches retire here; loads/stores go to MEM
// MEM       | data access at ALU address; stores retire on mem_ready
// WRITEBACK | regfile write (except FENCE) and PC update
// HALT      | stopped after SYSTEM or an error; err held until start
module rv32i_multicycle_sequencer
  import rv32i_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [6:0]       i_opcode,
  input  logic             i_branch_taken,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_mem_addr_sel,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic [1:0]       o_pc_src,
  output logic             o_rf_we,
  output logic [1:0]       o_wb_sel,
  output logic             o_busy,
  output logic             o_halted,
  output logic [1:0]       o_err,
  output logic [2:0]       o_state_dbg,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instret_cnt
);

  // wide enough to hold MEM_TIMEOUT-1; the counter never needs to reach the limit itself
  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  iclass_e           r_iclass;
  logic [1:0]        r_err;
  logic [1:0]        w_err_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  iclass_e           w_dec_iclass;
  logic              w_dec_legal;
  logic              w_timeout;

  seq_opcode_decode u_decode (
    .i_opcode (i_opcode),
    .o_iclass (w_dec_iclass),
    .o_legal  (w_dec_legal)
  );

  // a ready arriving in the limit cycle wins over the timeout
  assign w_timeout = (MEM_TIMEOUT != 0) && !i_mem_ready && (r_wait_cnt == WAIT_LAST);

  assign o_state_dbg = r_state;
  assign o_busy      = (r_state != S_IDLE) && (r_state != S_HALT);
  assign o_halted    = (r_state == S_HALT);
  assign o_err       = r_err;

  // state, error and instruction-class registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_err    <= ERR_NONE;
      r_iclass <= IC_ALU;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      if (r_state == S_DECODE) r_iclass <= w_dec_iclass;
    end
  end

  // memory wait counter: cleared on any state change, counts not-ready access cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_FETCH || r_state == S_MEM) && !i_mem_ready) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // next-state and control outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_err_nxt      = r_err;
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr_sel = 1'b0;
    o_ir_write     = 1'b0;
    o_pc_write     = 1'b0;
    o_pc_src       = PC_SRC_PC4;
    o_rf_we        = 1'b0;
    o_wb_sel       = WB_SEL_ALU;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_ir_write  = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (w_timeout) begin
          w_err_nxt   = ERR_TIMEOUT;
          w_state_nxt = S_HALT;
        end
      end
      S_DECODE: begin
        if (!w_dec_legal) begin
          w_err_nxt   = ERR_ILLEGAL;
          w_state_nxt = S_HALT;
        end else if (w_dec_iclass == IC_SYSTEM) begin
          o_pc_write  = 1'b1;
          w_err_nxt   = ERR_NONE;
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (r_iclass)
          IC_BRANCH: begin
            o_pc_write  = 1'b1;
            o_pc_src    = i_branch_taken ? PC_SRC_IMM : PC_SRC_PC4;
            w_state_nxt = S_FETCH;
          end
          IC_LOAD, IC_STORE: w_state_nxt = S_MEM;
          default:           w_state_nxt = S_WRITEBACK;
        endcase
      end
      S_MEM: begin
        o_mem_req      = 1'b1;
        o_mem_addr_sel = 1'b1;
        o_mem_we       = (r_iclass == IC_STORE);
        if (i_mem_ready) begin
          if (r_iclass == IC_STORE) begin
            o_pc_write  = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WRITEBACK;
          end
        end else if (w_timeout) begin
          w_err_nxt   = ERR_TIMEOUT;
          w_state_nxt = S_HALT;
        end
      end
      S_WRITEBACK: begin
        o_pc_write = 1'b1;
        o_rf_we    = (r_iclass != IC_FENCE);
        case (r_iclass)
          IC_LOAD: o_wb_sel = WB_SEL_MEM;
          IC_JAL:  begin o_wb_sel = WB_SEL_PC4; o_pc_src = PC_SRC_IMM; end
          IC_JALR: begin o_wb_sel = WB_SEL_PC4; o_pc_src = PC_SRC_ALU; end
          default: o_wb_sel = WB_SEL_ALU;
        endcase
        w_state_nxt = S_FETCH;
      end
      S_HALT: begin
        if (i_start) begin
          w_err_nxt   = ERR_NONE;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  // free-running busy-cycle and retired-instruction counters, wrap naturally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (o_busy)     r_cycle_cnt   <= r_cycle_cnt + 1'b1;
      if (o_pc_write) r_instret_cnt <= r_instret_cnt + 1'b1;
    end
  end

  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_instret_cnt = r_instret_cnt;
`else
  assign o_cycle_cnt   = '0;
  assign o_instret_cnt = '0;
`endif

endmodule
